// File: rtl/mul_seq_arb_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mul_seq_pkg;

    localparam int DEF_W = 4;
    localparam int N_REQ = 2;
    localparam int CNT_W = $clog2(DEF_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int step_cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mul_seq_arb_if.sv
// Request/operand/result bundle between the two requesters and the multiplier.
interface mul_seq_arb_if
    import mul_seq_pkg::*;
#(
    parameter int W = DEF_W
);
    logic [N_REQ-1:0] req;
    logic [W-1:0]     a0;
    logic [W-1:0]     b0;
    logic [W-1:0]     a1;
    logic [W-1:0]     b1;
    logic [N_REQ-1:0] gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [2*W-1:0]   product;

    modport master (
        output req, a0, b0, a1, b1,
        input  gnt, busy, done, done_id, product
    );

    modport slave (
        input  req, a0, b0, a1, b1,
        output gnt, busy, done, done_id, product
    );
endinterface

// File: rtl/mul_seq_add.sv
// W-bit ripple-carry adder; the only adder in the multiplier datapath.
module mul_seq_add #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);
    logic [W:0] w_c;

    assign w_c[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
            assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (i_a[gi] & w_c[gi]) | (i_b[gi] & w_c[gi]);
        end
    endgenerate

    assign o_cout = w_c[W];
endmodule

// File: rtl/mul_seq_arb.sv
// Round-robin shared shift-add multiplier for two requesters.
// Optional MUL_SEQ_ZERO_SKIP_EN: finish early once remaining multiplier bits are zero.
module mul_seq_arb
    import mul_seq_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    mul_seq_arb_if.slave  bus
);
    localparam int             CW   = step_cnt_w(W);
    localparam logic [CW-1:0]  LAST = CW'(W - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic            r_ptr;
    logic            r_winner;
    logic [1:0]      r_gnt;
    logic [W-1:0]    r_mcand;
    logic [W-1:0]    r_mplier;
    logic [W-1:0]    r_acc_hi;
    logic [CW-1:0]   r_cnt;
    logic [2*W-1:0]  r_product;
    logic            r_done_id;

    logic            w_accept;
    logic            w_win;
    logic            w_last;
    logic [W-1:0]    w_addend;
    logic [W-1:0]    w_sum;
    logic            w_cout;
    logic [2*W-1:0]  w_shifted;

    assign w_accept = (r_state == IDLE) && (|bus.req);
    // Contention is settled by the pointer; a lone request wins outright.
    assign w_win    = (bus.req == 2'b11) ? r_ptr : bus.req[1];
    assign w_addend = r_mplier[0] ? r_mcand : '0;

    mul_seq_add #(.W(W)) u_add (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

`ifdef MUL_SEQ_ZERO_SKIP_EN
    // r_live marks which r_mplier bits are still unconsumed multiplier bits.
    logic [W-1:0] r_live;

    always_comb begin
        w_shifted = (2*W)'({w_cout, w_sum, r_mplier} >> 1);
        w_last    = (r_cnt == LAST) || ((r_mplier[W-1:1] & r_live[W-1:1]) == '0);
        if (w_last) begin
            for (int j = 1; j < W; j++) begin
                if (r_live[j]) begin
                    w_shifted = w_shifted >> 1;
                end
            end
        end
    end
`else
    always_comb begin
        w_shifted = (2*W)'({w_cout, w_sum, r_mplier} >> 1);
        w_last    = (r_cnt == LAST);
    end
`endif

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = RUN;
            RUN:     if (w_last)   w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_ptr     <= 1'b0;
            r_winner  <= 1'b0;
            r_gnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc_hi  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
            r_done_id <= 1'b0;
`ifdef MUL_SEQ_ZERO_SKIP_EN
            r_live    <= '0;
`endif
        end else begin
            r_state <= w_state_next;
            r_gnt   <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gnt    <= w_win ? 2'b10 : 2'b01;
                        r_winner <= w_win;
                        r_ptr    <= ~w_win;
                        r_mcand  <= w_win ? bus.a1 : bus.a0;
                        r_mplier <= w_win ? bus.b1 : bus.b0;
                        r_acc_hi <= '0;
                        r_cnt    <= '0;
`ifdef MUL_SEQ_ZERO_SKIP_EN
                        r_live   <= '1;
`endif
                    end
                end
                RUN: begin
                    r_acc_hi <= w_shifted[2*W-1:W];
                    r_mplier <= w_shifted[W-1:0];
                    r_cnt    <= r_cnt + 1'b1;
`ifdef MUL_SEQ_ZERO_SKIP_EN
                    r_live   <= r_live >> 1;
`endif
                    if (w_last) begin
                        r_product <= w_shifted;
                        r_done_id <= r_winner;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = (r_state != IDLE);
    assign bus.done    = (r_state == DONE);
    assign bus.done_id = r_done_id;
    assign bus.product = r_product;
endmodule
